// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller placed directly after the deadline timer.
//
// It latches rising edges of the timer's `timeout` line and of the external
// IRQ lines into a pending register. It then requests service from the CPU
// pipeline and waits for an acknowledge. On the acknowledge it captures the
// return PC and redirects fetch to the vector for the winning cause. On
// `eret` it redirects fetch back to the saved PC. It also drives the timer's
// start, stop and count-enable inputs.
//
// Ports
//   cpu_clk, rst        clock (posedge); synchronous active-high reset
//   timeout             timer expiry level (edge-detected here)
//   ext_irq[N_EXT]      external IRQ levels, already synchronised (edge-detected)
//   mask_we/mask_wdata  enable-mask write; bit 0 = timeout, bit i+1 = ext_irq[i]
//   instr_commit        one instruction retired this cycle
//   task_start          software request to start the task deadline
//   eret                return-from-interrupt committed
//   cpu_ack, pc_in      pipeline drained; pc_in is the return address
//   irq_req             request to the pipeline
//   redirect, vector_pc one-cycle fetch redirect and its target
//   epc, cause          saved return PC and index of the serviced source
//   in_handler          a handler is running
//   start_time          timer start pulse
//   stop_timer          timer stop pulse
//   count_en            timer instruction-count enable
//
// States
//   IDLE    | no request outstanding; task_start is honoured
//   REQ     | irq_req held, waiting for cpu_ack
//   HANDLER | handler running; wait for eret
module irq_ctrl #(
    parameter int          N_EXT           = 3,
    parameter logic [31:0] VECTOR_BASE     = 32'h0000_0080,
    parameter logic [31:0] VECTOR_STRIDE   = 32'h0000_0010,
    parameter bit          RESTART_ON_ERET = 1'b1
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic             timeout,
    input  logic [N_EXT-1:0] ext_irq,
    input  logic             mask_we,
    input  logic [N_EXT:0]   mask_wdata,
    input  logic             instr_commit,
    input  logic             task_start,
    input  logic             eret,
    input  logic             cpu_ack,
    input  logic [31:0]      pc_in,
    output logic             irq_req,
    output logic             redirect,
    output logic [31:0]      vector_pc,
    output logic [31:0]      epc,
    output logic [3:0]       cause,
    output logic             in_handler,
    output logic             start_time,
    output logic             stop_timer,
    output logic             count_en
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_EXT:0]   pending_q, pending_d;
    logic [N_EXT:0]   mask_q, mask_d;
    logic             timeout_dly_q, timeout_dly_d;
    logic [N_EXT-1:0] ext_dly_q, ext_dly_d;
    logic             irq_req_q, irq_req_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      vector_pc_q, vector_pc_d;
    logic [31:0]      epc_q, epc_d;
    logic [3:0]       cause_q, cause_d;
    logic             in_handler_q, in_handler_d;
    logic             start_time_q, start_time_d;
    logic             stop_timer_q, stop_timer_d;

    logic [N_EXT:0]   set_bits;
    logic [N_EXT:0]   clr_bits;
    logic [N_EXT:0]   eligible;
    logic [3:0]       win_idx;

    assign set_bits = {ext_irq & ~ext_dly_q, timeout & ~timeout_dly_q};
    assign eligible = pending_q & mask_q;

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        win_idx = 4'd0;
        for (int i = N_EXT; i >= 0; i--) begin
            if (eligible[i]) win_idx = 4'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_we ? mask_wdata : mask_q;
        timeout_dly_d = timeout;
        ext_dly_d     = ext_irq;
        irq_req_d     = 1'b0;
        redirect_d    = 1'b0;
        vector_pc_d   = vector_pc_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        in_handler_d  = in_handler_q;
        start_time_d  = 1'b0;
        stop_timer_d  = 1'b0;
        clr_bits      = '0;

        case (state_q)
            IDLE: begin
                // Guard keeps a held task_start (or one right after an
                // eret restart) from merging into a multi-cycle pulse.
                if (task_start && !start_time_q) start_time_d = 1'b1;
                if (|eligible) begin
                    state_d   = REQ;
                    irq_req_d = 1'b1;
                end
            end
            REQ: begin
                if (!(|eligible)) begin
                    state_d = IDLE;
                end else if (cpu_ack) begin
                    epc_d              = pc_in;
                    cause_d            = win_idx;
                    clr_bits[win_idx]  = 1'b1;
                    redirect_d         = 1'b1;
                    vector_pc_d        = VECTOR_BASE + ({28'd0, win_idx} * VECTOR_STRIDE);
                    stop_timer_d       = 1'b1;
                    in_handler_d       = 1'b1;
                    state_d            = HANDLER;
                end else begin
                    irq_req_d = 1'b1;
                end
            end
            HANDLER: begin
                if (eret) begin
                    redirect_d   = 1'b1;
                    vector_pc_d  = epc_q;
                    in_handler_d = 1'b0;
                    start_time_d = RESTART_ON_ERET;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge in the same cycle as the service clear keeps the bit set.
        pending_d = (pending_q & ~clr_bits) | set_bits;
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            mask_q        <= '1;
            timeout_dly_q <= 1'b0;
            ext_dly_q     <= '0;
            irq_req_q     <= 1'b0;
            redirect_q    <= 1'b0;
            vector_pc_q   <= 32'd0;
            epc_q         <= 32'd0;
            cause_q       <= 4'd0;
            in_handler_q  <= 1'b0;
            start_time_q  <= 1'b0;
            stop_timer_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            timeout_dly_q <= timeout_dly_d;
            ext_dly_q     <= ext_dly_d;
            irq_req_q     <= irq_req_d;
            redirect_q    <= redirect_d;
            vector_pc_q   <= vector_pc_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            in_handler_q  <= in_handler_d;
            start_time_q  <= start_time_d;
            stop_timer_q  <= stop_timer_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign redirect   = redirect_q;
    assign vector_pc  = vector_pc_q;
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_handler = in_handler_q;
    assign start_time = start_time_q;
    assign stop_timer = stop_timer_q;
    // Handler instructions are not charged to the task's budget.
    assign count_en   = instr_commit & ~in_handler_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    logic        cpu_clk;
    logic        rst;
    logic        timeout;
    logic [2:0]  ext_irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        instr_commit;
    logic        task_start;
    logic        eret;
    logic        cpu_ack;
    logic [31:0] pc_in;
    logic        irq_req;
    logic        redirect;
    logic [31:0] vector_pc;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic        in_handler;
    logic        start_time;
    logic        stop_timer;
    logic        count_en;

    int n_vec;
    int n_err;

    irq_ctrl dut (
        .cpu_clk      (cpu_clk),
        .rst          (rst),
        .timeout      (timeout),
        .ext_irq      (ext_irq),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .instr_commit (instr_commit),
        .task_start   (task_start),
        .eret         (eret),
        .cpu_ack      (cpu_ack),
        .pc_in        (pc_in),
        .irq_req      (irq_req),
        .redirect     (redirect),
        .vector_pc    (vector_pc),
        .epc          (epc),
        .cause        (cause),
        .in_handler   (in_handler),
        .start_time   (start_time),
        .stop_timer   (stop_timer),
        .count_en     (count_en)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; timeout = 1'b0; ext_irq = 3'b000; mask_we = 1'b0;
        mask_wdata = 4'b1111; instr_commit = 1'b0; task_start = 1'b0;
        eret = 1'b0; cpu_ack = 1'b0; pc_in = 32'd0;
        step(); step();
        rst = 1'b0;
        n_vec++;
        if ({irq_req, redirect, in_handler, start_time, stop_timer, count_en} !== 6'b0) begin
            $display("FAIL reset_flags got %b want 000000",
                     {irq_req, redirect, in_handler, start_time, stop_timer, count_en});
            n_err++;
        end
        n_vec++;
        if ({vector_pc, epc, cause} !== 68'd0) begin
            $display("FAIL reset_regs got vpc=%h epc=%h cause=%0d want 0", vector_pc, epc, cause);
            n_err++;
        end
        step();
        n_vec++;
        if (irq_req !== 1'b0) begin
            $display("FAIL idle_no_req got %b want 0", irq_req);
            n_err++;
        end
    endtask

    task automatic test_timeout_req();
        timeout = 1'b1;
        step();
        n_vec++;
        if (irq_req !== 1'b0) begin
            $display("FAIL req_latency1 got %b want 0", irq_req);
            n_err++;
        end
        step();
        n_vec++;
        if (irq_req !== 1'b1) begin
            $display("FAIL req_rise got %b want 1", irq_req);
            n_err++;
        end
        step();
        timeout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (irq_req !== 1'b1) begin
                $display("FAIL req_hold[%0d] got %b want 1", i, irq_req);
                n_err++;
            end
            step();
        end
    endtask

    task automatic test_ack();
        pc_in = 32'h0000_0400; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_vec++;
        if ({redirect, stop_timer, in_handler, irq_req} !== 4'b1110) begin
            $display("FAIL ack_flags got %b want 1110", {redirect, stop_timer, in_handler, irq_req});
            n_err++;
        end
        n_vec++;
        if (vector_pc !== 32'h0000_0080 || epc !== 32'h0000_0400 || cause !== 4'd0) begin
            $display("FAIL ack_regs got vpc=%h epc=%h cause=%0d want 80/400/0", vector_pc, epc, cause);
            n_err++;
        end
        step();
        n_vec++;
        if ({redirect, stop_timer, in_handler} !== 3'b001) begin
            $display("FAIL ack_pulse_end got %b want 001", {redirect, stop_timer, in_handler});
            n_err++;
        end
    endtask

    task automatic test_handler_back_to_back();
        instr_commit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (count_en !== 1'b0) begin
                $display("FAIL count_en_handler[%0d] got %b want 0", i, count_en);
                n_err++;
            end
            step();
        end
        instr_commit = 1'b0;
        ext_irq = 3'b010;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (irq_req !== 1'b0) begin
                $display("FAIL handler_no_req[%0d] got %b want 0", i, irq_req);
                n_err++;
            end
        end
        ext_irq = 3'b000;
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++;
        if ({redirect, start_time, in_handler, irq_req} !== 4'b1100 || vector_pc !== 32'h0000_0400) begin
            $display("FAIL eret_return got flags=%b vpc=%h want 1100/400",
                     {redirect, start_time, in_handler, irq_req}, vector_pc);
            n_err++;
        end
        step();
        n_vec++;
        if ({irq_req, redirect, start_time} !== 3'b100) begin
            $display("FAIL b2b_req got %b want 100", {irq_req, redirect, start_time});
            n_err++;
        end
        pc_in = 32'h0000_0500; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_vec++;
        if (redirect !== 1'b1 || cause !== 4'd2 || vector_pc !== 32'h0000_00A0 || epc !== 32'h0000_0500) begin
            $display("FAIL b2b_ack got rd=%b cause=%0d vpc=%h epc=%h want 1/2/a0/500",
                     redirect, cause, vector_pc, epc);
            n_err++;
        end
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++;
        if (redirect !== 1'b1 || vector_pc !== 32'h0000_0500) begin
            $display("FAIL b2b_eret got rd=%b vpc=%h want 1/500", redirect, vector_pc);
            n_err++;
        end
        step(); step();
        // timeout was high for three cycles but must have latched only once
        n_vec++;
        if (irq_req !== 1'b0) begin
            $display("FAIL timeout_latched_once got %b want 0", irq_req);
            n_err++;
        end
        instr_commit = 1'b1;
        #1;
        n_vec++;
        if (count_en !== 1'b1) begin
            $display("FAIL count_en_task got %b want 1", count_en);
            n_err++;
        end
        instr_commit = 1'b0;
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_wdata = 4'b1000;
        step();
        mask_we = 1'b0;
        ext_irq = 3'b100; timeout = 1'b1;
        step();
        step();
        ext_irq = 3'b000; timeout = 1'b0;
        n_vec++;
        if (irq_req !== 1'b1) begin
            $display("FAIL mask_req got %b want 1", irq_req);
            n_err++;
        end
        pc_in = 32'h0000_0600; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_vec++;
        if (cause !== 4'd3 || vector_pc !== 32'h0000_00B0) begin
            $display("FAIL mask_cause got cause=%0d vpc=%h want 3/b0", cause, vector_pc);
            n_err++;
        end
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        step(); step();
        n_vec++;
        if (irq_req !== 1'b0) begin
            $display("FAIL masked_timeout_req got %b want 0", irq_req);
            n_err++;
        end
        mask_we = 1'b1; mask_wdata = 4'b0001;
        step();
        mask_we = 1'b0;
        step();
        n_vec++;
        if (irq_req !== 1'b1) begin
            $display("FAIL unmask_req got %b want 1", irq_req);
            n_err++;
        end
        pc_in = 32'h0000_0700; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_vec++;
        if (cause !== 4'd0 || vector_pc !== 32'h0000_0080 || epc !== 32'h0000_0700) begin
            $display("FAIL unmask_cause got cause=%0d vpc=%h epc=%h want 0/80/700", cause, vector_pc, epc);
            n_err++;
        end
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        mask_we = 1'b1; mask_wdata = 4'b1111;
        step();
        mask_we = 1'b0;
        step();
    endtask

    task automatic test_task_start();
        task_start = 1'b1;
        step();
        task_start = 1'b0;
        n_vec++;
        if (start_time !== 1'b1) begin
            $display("FAIL start_pulse got %b want 1", start_time);
            n_err++;
        end
        step();
        n_vec++;
        if (start_time !== 1'b0) begin
            $display("FAIL start_pulse_end got %b want 0", start_time);
            n_err++;
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++;
        if (redirect !== 1'b0 || start_time !== 1'b0) begin
            $display("FAIL eret_idle got rd=%b st=%b want 0/0", redirect, start_time);
            n_err++;
        end
        ext_irq = 3'b001;
        step(); step();
        ext_irq = 3'b000;
        cpu_ack = 1'b1; pc_in = 32'h0000_0800;
        step();
        cpu_ack = 1'b0;
        n_vec++;
        if (cause !== 4'd1 || vector_pc !== 32'h0000_0090 || in_handler !== 1'b1) begin
            $display("FAIL ext0_cause got cause=%0d vpc=%h ih=%b want 1/90/1", cause, vector_pc, in_handler);
            n_err++;
        end
        step();
        task_start = 1'b1;
        step();
        task_start = 1'b0;
        n_vec++;
        if (start_time !== 1'b0) begin
            $display("FAIL start_in_handler got %b want 0", start_time);
            n_err++;
        end
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++;
        if (start_time !== 1'b1 || vector_pc !== 32'h0000_0800) begin
            $display("FAIL eret_restart got st=%b vpc=%h want 1/800", start_time, vector_pc);
            n_err++;
        end
        step();
    endtask

    task automatic test_reset_in_req();
        timeout = 1'b1;
        step();
        timeout = 1'b0;
        step();
        n_vec++;
        if (irq_req !== 1'b1) begin
            $display("FAIL rst_setup_req got %b want 1", irq_req);
            n_err++;
        end
        rst = 1'b1; cpu_ack = 1'b1; pc_in = 32'h0000_0900;
        step();
        rst = 1'b0; cpu_ack = 1'b0;
        n_vec++;
        if ({irq_req, redirect, in_handler, start_time, stop_timer} !== 5'b0 ||
            vector_pc !== 32'd0 || epc !== 32'd0 || cause !== 4'd0) begin
            $display("FAIL rst_in_req got flags=%b vpc=%h epc=%h cause=%0d want all 0",
                     {irq_req, redirect, in_handler, start_time, stop_timer}, vector_pc, epc, cause);
            n_err++;
        end
        step(); step();
        n_vec++;
        if (irq_req !== 1'b0) begin
            $display("FAIL rst_pending_clr got %b want 0", irq_req);
            n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_timeout_req();
        test_ack();
        test_handler_back_to_back();
        test_mask();
        test_task_start();
        test_reset_in_req();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
